// File: rtl/neuron_accumulate_relu.sv
// neuron_accumulate_relu: saturating accumulate of N_TERMS partial sums, bias add, ReLU,
// rescale and clamp, one activation per neuron over valid/ready streams.
module neuron_accumulate_relu #(
    parameter int IN_W    = 19,
    parameter int BIAS_W  = 18,
    parameter int ACC_W   = 26,
    parameter int N_TERMS = 392,
    parameter int SHIFT   = 8,
    parameter int OUT_W   = 18
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   sum_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [BIAS_W-1:0] bias,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     ovf,
    output logic                     busy
);
    localparam int CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);

    typedef enum logic [1:0] {S_ACC, S_BIAS, S_ACT, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic                     busy_q, busy_d;
    logic                     ready_q, ready_d;

    logic signed [ACC_W:0]    addend, sum_full;
    logic signed [ACC_W-1:0]  sum_sat, shifted, relu;
    logic                     sat, accept;

    // One adder serves both the beat accumulation and the bias add; a sign
    // mismatch in the top two bits of the widened sum means the result clamps.
    always_comb begin
        addend   = (state_q == S_BIAS) ? (ACC_W+1)'(bias) : (ACC_W+1)'(sum_in);
        sum_full = {acc_q[ACC_W-1], acc_q} + addend;
        sat      = sum_full[ACC_W] != sum_full[ACC_W-1];
        sum_sat  = sat ? (sum_full[ACC_W] ? ACC_MIN : ACC_MAX) : sum_full[ACC_W-1:0];
        shifted  = acc_q >>> SHIFT;
        relu     = acc_q[ACC_W-1] ? '0 : ((shifted > OUT_MAX) ? OUT_MAX : shifted);
        accept   = (state_q == S_ACC) && ready_q && in_valid;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d   = sum_sat;
                    ovf_d   = ovf_q | sat;
                    busy_d  = 1'b1;
                    cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
                    state_d = (cnt_q == LAST) ? S_BIAS : S_ACC;
                end
            end
            S_BIAS: begin
                acc_d   = sum_sat;
                ovf_d   = ovf_q | sat;
                state_d = S_ACT;
            end
            S_ACT: begin
                out_d   = OUT_W'(relu);
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
        ready_d = state_d == S_ACC;
    end

    // in_ready is registered so it stays low during reset and rises one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = out_q;
    assign out_valid = valid_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_neuron_accumulate_relu.sv
// tb_neuron_accumulate_relu: directed per-scenario checks of accumulate, bias,
// ReLU, saturation, backpressure, bubbles and asynchronous reset.
module tb_neuron_accumulate_relu;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [18:0] sum_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [17:0] bias = '0;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               ovf;
    logic               busy;
    int                 vectors = 0;
    int                 miscompares = 0;

    neuron_accumulate_relu #(
        .IN_W(19), .BIAS_W(18), .ACC_W(20), .N_TERMS(4), .SHIFT(2), .OUT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid), .in_ready(in_ready),
        .bias(bias), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic send_beat(input int v);
        sum_in   = 19'(v);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        miscompares++;
        $display("FAIL send_beat_timeout got in_ready=0 want in_ready=1 within 50 cycles");
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, ovf, busy} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_flags got rdy/vld/ovf/busy=%b want 0000", {in_ready, out_valid, ovf, busy});
        end
        vectors++;
        if (out_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_data got %0d want 0", out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        int cyc;
        bias = 18'sd4;
        out_ready = 1'b1;
        send_beat(10);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_busy got %b want 1", busy);
        end
        send_beat(20);
        send_beat(30);
        send_beat(40);
        wait_out(cyc);
        vectors++;
        if (cyc != 2) begin
            miscompares++;
            $display("FAIL basic_latency got %0d want 2", cyc);
        end
        vectors++;
        if (out_data !== 8'd26 || ovf !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_out got data=%0d ovf=%b rdy=%b want 26 0 0", out_data, ovf, in_ready);
        end
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL basic_after got vld/rdy/busy=%b want 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_relu;
        int cyc;
        bias = 18'sd0;
        send_beat(-100);
        send_beat(10);
        send_beat(10);
        send_beat(10);
        wait_out(cyc);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
            miscompares++;
            $display("FAIL relu_out got vld=%b data=%0d want 1 0", out_valid, out_data);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL relu_pulse got %b want 0", out_valid);
        end
    endtask

    task automatic test_saturation;
        int cyc;
        bias = 18'sd0;
        for (int i = 0; i < 4; i++) send_beat(262143);
        wait_out(cyc);
        vectors++;
        if (out_data !== 8'd127 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_out got data=%0d ovf=%b want 127 1", out_data, ovf);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_beat(1);
        wait_out(cyc);
        vectors++;
        if (out_data !== 8'd1 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_next got data=%0d ovf=%b want 1 0", out_data, ovf);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int cyc;
        bias = 18'sd0;
        out_ready = 1'b0;
        send_beat(1);
        send_beat(2);
        send_beat(3);
        send_beat(4);
        wait_out(cyc);
        sum_in   = 19'sd99;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'd2 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold got vld=%b data=%0d rdy=%b want 1 2 0", out_valid, out_data, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 4; i++) send_beat(8);
        wait_out(cyc);
        vectors++;
        if (out_data !== 8'd8 || cyc != 2) begin
            miscompares++;
            $display("FAIL bp_second got data=%0d lat=%0d want 8 2", out_data, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_bubbles;
        int cyc;
        bias = -18'sd4;
        for (int i = 0; i < 3; i++) begin
            send_beat(5);
            repeat (i + 1) @(negedge clk);
        end
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bubble_mid got vld=%b busy=%b rdy=%b want 0 1 1", out_valid, busy, in_ready);
        end
        send_beat(5);
        wait_out(cyc);
        vectors++;
        if (out_data !== 8'd4 || cyc != 2) begin
            miscompares++;
            $display("FAIL bubble_out got data=%0d lat=%0d want 4 2", out_data, cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bias = 18'sd4;
        out_ready = 1'b0;
        send_beat(10);
        send_beat(20);
        send_beat(30);
        send_beat(40);
        wait_out(cyc);
        vectors++;
        if (out_data !== 8'd26) begin
            miscompares++;
            $display("FAIL rst_pre got %0d want 26", out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_data !== 8'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async got data=%0d vld=%b busy=%b want 0 0 0", out_data, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        bias = 18'sd0;
        @(negedge clk);
        send_beat(100);
        send_beat(100);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid got busy=%b rdy=%b want 0 0", busy, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(1);
        send_beat(2);
        send_beat(3);
        send_beat(6);
        wait_out(cyc);
        vectors++;
        if (out_data !== 8'd3 || ovf !== 1'b0 || cyc != 2) begin
            miscompares++;
            $display("FAIL rst_fresh got data=%0d ovf=%b lat=%0d want 3 0 2", out_data, ovf, cyc);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/neuron_accumulate_relu.md
Name: neuron_accumulate_relu

Overview:
Downstream consumer of the 18-bit pairwise product adders in the hidden/output neuron datapath. It takes the 19-bit signed partial sums one beat at a time over a valid/ready stream and accumulates N_TERMS beats with saturation. It then adds the neuron bias, applies ReLU, scales and clamps, and presents one activation per neuron on an output valid/ready stream.

Parameters:
IN_W, 19, width of signed partial-sum input (adder output width)
BIAS_W, 18, width of signed bias input
ACC_W, 26, signed accumulator width
N_TERMS, 392, partial sums per neuron (784 pixels / 2 per adder)
SHIFT, 8, arithmetic right shift applied after ReLU (fixed-point rescale)
OUT_W, 18, signed output width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
sum_in  in  IN_W  signed partial sum from adder stage
in_valid  in  1  sum_in valid
in_ready  out  1  block accepts sum_in this cycle
bias  in  BIAS_W  signed neuron bias; stable from first beat of a neuron until out_valid
out_data  out  OUT_W  signed activation, always >= 0
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
ovf  out  1  sticky: accumulator or bias add saturated for current neuron
busy  out  1  high from first accepted beat until output handshake

Behaviour:
- One clock; reset is asynchronous and active-low. While rst_n=0: state=ACC, acc=0, count=0, out_data=0, out_valid=0, ovf=0, busy=0. in_ready=1 one cycle after rst_n rises.
- States:
  - ACC: in_ready=1. Beat accepted when in_valid&in_ready. acc <= sat_ACC_W(acc + sext(sum_in)), count++, busy<=1. Accepting the beat with count==N_TERMS-1 -> BIAS, count<=0. Cycles with in_valid=0 change nothing.
  - BIAS: in_ready=0, single cycle. acc <= sat_ACC_W(acc + sext(bias)) -> ACT.
  - ACT: in_ready=0, single cycle. If acc<0, r=0; else r=acc>>>SHIFT. Clamp r to 2^(OUT_W-1)-1. out_data<=r, out_valid<=1 -> OUT.
  - OUT: in_ready=0. out_data held stable until out_valid&out_ready. On handshake: out_valid<=0, acc<=0, ovf<=0, busy<=0 -> ACC. in_ready returns the next cycle; there is no same-cycle bypass.
- Latency: last beat accepted at edge t gives out_valid=1 after edge t+2.
- Saturation:
  - sat_ACC_W clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp in ACC or BIAS sets ovf, which stays high through OUT.
  - The accumulator never wraps.
- out_data is 0 or positive only; out_data[OUT_W-1] is always 0.
- out_data, out_valid, in_ready and busy are registered or decoded directly from state. There is no combinational path from in_valid or out_ready to any output.
- Reset mid-operation, in any state, discards the partial neuron. The block returns to reset values and the next accepted beat starts a fresh neuron with count 0.

Test Plan:
Bench overrides: N_TERMS=4, SHIFT=2, OUT_W=8, ACC_W=20.
1. Basic: sums 10,20,30,40 on consecutive cycles, bias=4, out_ready=1 -> acc 104, out_data=26, out_valid exactly 2 cycles after the 4th beat, ovf=0.
2. ReLU: sums -100,10,10,10, bias=0 -> acc -70, out_data=0, out_valid pulses once.
3. Saturation: four beats of 262143, bias=0 -> acc clamps at 524287, ovf=1, out_data=127 (clamped). A following neuron of 1,1,1,1 with bias 0 gives out_data=1 and ovf=0.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, beats offered are not consumed. Raising out_ready completes the handshake, in_ready=1 the next cycle, and the second neuron is computed from acc=0.
5. Bubbles: sums 5,5,5,5 with in_valid low 1-3 cycles between beats, bias=-4 -> out_data=4 and count advances only on handshakes.
6. Reset mid-neuron: accept 100,100, pulse rst_n low asynchronously between edges -> outputs go to 0 immediately. Then 1,2,3,6 with bias 0 -> out_data=3, ovf=0.
